// File: rtl/gamectrl_pkg.sv
// Shared types and constants for the Tetris game controller.
// State encoding, one-hot move request codes, default board geometry and
// the saturating score helper.
package gamectrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SPAWN = 4'd1,
    S_FALL  = 4'd2,
    S_CHECK = 4'd3,
    S_LOCK  = 4'd4,
    S_CLEAR = 4'd5,
    S_OVER  = 4'd6
  } state_t;

  // One-hot grant codes produced by the request arbiter.
  localparam logic [3:0] REQ_GRAV  = 4'b0001;
  localparam logic [3:0] REQ_ROT   = 4'b0010;
  localparam logic [3:0] REQ_LEFT  = 4'b0100;
  localparam logic [3:0] REQ_RIGHT = 4'b1000;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int SPAWN_X_DEF = 4;

  // Add cleared lines to the score; more than 4 lines is treated as 4 and
  // the result saturates at 31.
  function automatic logic [4:0] score_add(input logic [4:0] s, input logic [2:0] lines);
    logic [2:0] l;
    logic [5:0] sum;
    l   = (lines > 3'd4) ? 3'd4 : lines;
    sum = {1'b0, s} + {3'b000, l};
    return (sum > 6'd31) ? 5'd31 : sum[4:0];
  endfunction

endpackage

// File: rtl/gamectrl_req_arb.sv
// Pending move requests and their priority pick.
// Holds one sticky bit per request source (gravity, rotate, left, right).
// Grant priority is gravity > rotate > left/right; left and right pending
// together cancel each other (both cleared when taken, no grant issued).
module gamectrl_req_arb
  import gamectrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       flush,
  input  logic       take,
  input  logic       tick_gravity,
  input  logic       rot_final,
  input  logic       left_final,
  input  logic       right_final,
  output logic [3:0] grant
);

  // Bit order follows the REQ_* codes: [0]=gravity [1]=rot [2]=left [3]=right.
  logic [3:0] pend_q;
  logic [3:0] set_v;
  logic [3:0] clr_v;
  logic       cancel;

  // Priority pick plus left/right cancel detection.
  always_comb begin
    grant  = 4'b0000;
    cancel = 1'b0;
    if (pend_q[0])                  grant  = REQ_GRAV;
    else if (pend_q[1])             grant  = REQ_ROT;
    else if (pend_q[2] && pend_q[3]) cancel = 1'b1;
    else if (pend_q[2])             grant  = REQ_LEFT;
    else if (pend_q[3])             grant  = REQ_RIGHT;
  end

  assign set_v = en ? {right_final, left_final, rot_final, tick_gravity} : 4'b0000;
  assign clr_v = flush ? 4'b1111 :
                 take  ? (grant | (cancel ? (REQ_LEFT | REQ_RIGHT) : 4'b0000)) :
                         4'b0000;

  // Pending bits; a new pulse wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) pend_q <= 4'b0000;
    else         pend_q <= (pend_q & ~clr_v) | set_v;
  end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Master sequencer for the Tetris gamelogic datapath.
// Owns the active piece and the score, funnels moves through one shared
// collision-checker port, and runs lock -> clear -> spawn with the board.
// Optional macro GAMECTRL_WATCHDOG_EN adds a checker timeout and the
// sticky chk_err output.
module game_ctrl_fsm
  import gamectrl_pkg::*;
#(
`ifdef GAMECTRL_WATCHDOG_EN
  parameter int CHK_TIMEOUT = 15,
`endif
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int SPAWN_X = SPAWN_X_DEF
)(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       left_final,
  input  logic       right_final,
  input  logic       rot_final,
  input  logic       tick_gravity,
  output logic       chk_req,
  output logic [4:0] cand_x,
  output logic [4:0] cand_y,
  output logic [2:0] cand_rot,
  input  logic       chk_done,
  input  logic       collide,
  output logic       lock_req,
  input  logic       lock_done,
  output logic       clear_req,
  input  logic       clear_done,
  input  logic [2:0] lines_cleared,
  output logic [4:0] piece_x,
  output logic [4:0] piece_y,
  output logic [2:0] rot,
  output logic [2:0] shape_id,
  output logic [4:0] score,
  output logic [3:0] state,
  output logic       move_accept,
`ifdef GAMECTRL_WATCHDOG_EN
  output logic       chk_err,
`endif
  output logic       game_over
);

  // Handshakes: chk_req is a one-cycle strobe at the start of a check with
  // cand_* held until chk_done; lock_req/clear_req are levels held until
  // their done input is seen high at a clock edge.

  state_t     state_q, state_nxt;
  logic       chk_sent_q;
  logic [2:0] lfsr_q, lfsr_nxt;
  logic       cand_grav_q;
  logic       in_wait, resp_valid, resp_collide;
  logic       cand_ld, cand_grav_nxt;
  logic [4:0] cand_x_nxt, cand_y_nxt;
  logic [2:0] cand_rot_nxt;
  logic       commit, spawn_init, score_upd, score_clr, arb_take, arb_en;
  logic [3:0] grant;

  assign in_wait   = (state_q == S_SPAWN) || (state_q == S_CHECK);
  assign chk_req   = in_wait && !chk_sent_q;
  assign lock_req  = (state_q == S_LOCK);
  assign clear_req = (state_q == S_CLEAR);
  assign game_over = (state_q == S_OVER);
  assign state     = state_q;
  assign arb_en    = (state_q == S_FALL) || (state_q == S_CHECK);
  // x^3+x^2+1 shift register; never reaches zero from a non-zero seed.
  assign lfsr_nxt  = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};

`ifdef GAMECTRL_WATCHDOG_EN
  logic [3:0] wd_cnt_q;
  logic       wd_fire;
  assign wd_fire      = in_wait && !chk_done && (wd_cnt_q == 4'(CHK_TIMEOUT - 1));
  assign resp_valid   = chk_done || wd_fire;
  assign resp_collide = chk_done ? collide : 1'b1;

  // Watchdog: counts wait cycles of a check; a timeout reads as a collision.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      wd_cnt_q <= 4'd0;
      chk_err  <= 1'b0;
    end else begin
      wd_cnt_q <= (in_wait && (state_nxt == state_q)) ? wd_cnt_q + 4'd1 : 4'd0;
      if (wd_fire) chk_err <= 1'b1;
    end
  end
`else
  assign resp_valid   = chk_done;
  assign resp_collide = collide;
`endif

  gamectrl_req_arb u_arb (
    .clk          (CLOCK_50),
    .resetn       (resetn),
    .en           (arb_en),
    .flush        (spawn_init),
    .take         (arb_take),
    .tick_gravity (tick_gravity),
    .rot_final    (rot_final),
    .left_final   (left_final),
    .right_final  (right_final),
    .grant        (grant)
  );

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt     = state_q;
    cand_ld       = 1'b0;
    cand_x_nxt    = piece_x;
    cand_y_nxt    = piece_y;
    cand_rot_nxt  = rot;
    cand_grav_nxt = 1'b0;
    commit        = 1'b0;
    spawn_init    = 1'b0;
    score_upd     = 1'b0;
    score_clr     = 1'b0;
    arb_take      = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nxt  = S_SPAWN;
          score_clr  = (state_q == S_OVER);
          cand_ld    = 1'b1;
          cand_x_nxt = 5'(SPAWN_X);
          cand_y_nxt = 5'd0;
          cand_rot_nxt = 3'd0;
        end
      end
      S_SPAWN: begin
        spawn_init = !chk_sent_q;
        if (resp_valid) state_nxt = resp_collide ? S_OVER : S_FALL;
      end
      S_FALL: begin
        arb_take = 1'b1;
        if (grant == REQ_GRAV) begin
          if (piece_y == 5'(BOARD_H - 1)) begin
            state_nxt = S_LOCK;
          end else begin
            cand_ld       = 1'b1;
            cand_y_nxt    = piece_y + 5'd1;
            cand_grav_nxt = 1'b1;
            state_nxt     = S_CHECK;
          end
        end else if (grant == REQ_ROT) begin
          cand_ld      = 1'b1;
          cand_rot_nxt = {1'b0, rot[1:0] + 2'd1};
          state_nxt    = S_CHECK;
        end else if ((grant == REQ_LEFT) && (piece_x != 5'd0)) begin
          cand_ld    = 1'b1;
          cand_x_nxt = piece_x - 5'd1;
          state_nxt  = S_CHECK;
        end else if ((grant == REQ_RIGHT) && (piece_x != 5'(BOARD_W - 1))) begin
          cand_ld    = 1'b1;
          cand_x_nxt = piece_x + 5'd1;
          state_nxt  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (resp_valid) begin
          if (!resp_collide) begin
            commit    = 1'b1;
            state_nxt = S_FALL;
          end else begin
            state_nxt = cand_grav_q ? S_LOCK : S_FALL;
          end
        end
      end
      S_LOCK: begin
        if (lock_done) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (clear_done) begin
          score_upd    = 1'b1;
          state_nxt    = S_SPAWN;
          cand_ld      = 1'b1;
          cand_x_nxt   = 5'(SPAWN_X);
          cand_y_nxt   = 5'd0;
          cand_rot_nxt = 3'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, piece/score/candidate registers and the shape LFSR.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      chk_sent_q  <= 1'b0;
      lfsr_q      <= 3'b001;
      piece_x     <= 5'(SPAWN_X);
      piece_y     <= 5'd0;
      rot         <= 3'd0;
      shape_id    <= 3'd1;
      score       <= 5'd0;
      move_accept <= 1'b0;
      cand_x      <= 5'(SPAWN_X);
      cand_y      <= 5'd0;
      cand_rot    <= 3'd0;
      cand_grav_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      chk_sent_q  <= in_wait && (state_nxt == state_q);
      move_accept <= commit;
      if (cand_ld) begin
        cand_x      <= cand_x_nxt;
        cand_y      <= cand_y_nxt;
        cand_rot    <= cand_rot_nxt;
        cand_grav_q <= cand_grav_nxt;
      end
      if (spawn_init) begin
        lfsr_q   <= lfsr_nxt;
        shape_id <= lfsr_nxt - 3'd1;
        piece_x  <= 5'(SPAWN_X);
        piece_y  <= 5'd0;
        rot      <= 3'd0;
      end
      if (commit) begin
        piece_x <= cand_x;
        piece_y <= cand_y;
        rot     <= cand_rot;
      end
      if (score_clr)      score <= 5'd0;
      else if (score_upd) score <= score_add(score, lines_cleared);
    end
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm with a candidate scoreboard.
module tb_game_ctrl_fsm;

  logic       CLOCK_50;
  logic       resetn, start, left_final, right_final, rot_final, tick_gravity;
  logic       chk_req, chk_done, collide;
  logic [4:0] cand_x, cand_y;
  logic [2:0] cand_rot;
  logic       lock_req, lock_done, clear_req, clear_done;
  logic [2:0] lines_cleared;
  logic [4:0] piece_x, piece_y, score;
  logic [2:0] rot, shape_id;
  logic [3:0] state;
  logic       move_accept, game_over;
`ifdef GAMECTRL_WATCHDOG_EN
  logic       chk_err;
`endif

  game_ctrl_fsm dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .start         (start),
    .left_final    (left_final),
    .right_final   (right_final),
    .rot_final     (rot_final),
    .tick_gravity  (tick_gravity),
    .chk_req       (chk_req),
    .cand_x        (cand_x),
    .cand_y        (cand_y),
    .cand_rot      (cand_rot),
    .chk_done      (chk_done),
    .collide       (collide),
    .lock_req      (lock_req),
    .lock_done     (lock_done),
    .clear_req     (clear_req),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared),
    .piece_x       (piece_x),
    .piece_y       (piece_y),
    .rot           (rot),
    .shape_id      (shape_id),
    .score         (score),
    .state         (state),
    .move_accept   (move_accept),
`ifdef GAMECTRL_WATCHDOG_EN
    .chk_err       (chk_err),
`endif
    .game_over     (game_over)
  );

  // Clock and global time limit.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1);
  end

  // Scoreboard state: expected candidates {x,y,rot} and a small piece model.
  logic [12:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          chk_cnt = 0;
  logic [4:0]  mx, my;
  logic [2:0]  mrot;
  int          ms;
  int          spawn_idx;
  logic [2:0]  shape_seq [7];

  always @(posedge CLOCK_50) if (resetn && chk_req) chk_cnt = chk_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic pulse(input bit g, input bit r, input bit l, input bit h);
    tick_gravity = g; rot_final = r; left_final = l; right_final = h;
    cyc();
    tick_gravity = 1'b0; rot_final = 1'b0; left_final = 1'b0; right_final = 1'b0;
  endtask

  // Wait for chk_req, compare the candidate with the scoreboard, answer it.
  task automatic serve_chk(input string tag, input bit c);
    logic [12:0] obs_c;
    bit          seen;
    int          d;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (chk_req) seen = 1'b1;
    end
    check({tag, "_chk_req_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    obs_c = {cand_x, cand_y, cand_rot};
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check({tag, "_cand"}, 32'(obs_c), 32'(exp_q.pop_front()));
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      @(negedge CLOCK_50);
      check({tag, "_chk_req_one_cycle"}, 32'(chk_req), 32'd0);
      check({tag, "_cand_hold"}, 32'({cand_x, cand_y, cand_rot}), 32'(obs_c));
    end
    chk_done = 1'b1; collide = c;
    cyc();
    chk_done = 1'b0; collide = 1'b0;
  endtask

  // kind: 0=gravity 1=rotate 2=left 3=right
  task automatic do_move(input string tag, input int kind, input bit c);
    logic [4:0] ex, ey;
    logic [2:0] er;
    ex = mx; ey = my; er = mrot;
    case (kind)
      0: ey = my + 5'd1;
      1: er = 3'((mrot + 3'd1) % 4);
      2: ex = mx - 5'd1;
      default: ex = mx + 5'd1;
    endcase
    exp_q.push_back({ex, ey, er});
    pulse(kind == 0, kind == 1, kind == 2, kind == 3);
    serve_chk(tag, c);
    if (!c) begin mx = ex; my = ey; mrot = er; end
    check({tag, "_accept"}, 32'(move_accept), 32'(!c));
    check({tag, "_piece"}, 32'({piece_x, piece_y, rot}), 32'({mx, my, mrot}));
  endtask

  task automatic lock_clear_spawn(input string tag, input logic [2:0] lines, input bit spawn_c);
    bit seen;
    int l;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (lock_req) seen = 1'b1;
    end
    check({tag, "_lock_req"}, 32'(seen), 32'd1);
    lock_done = 1'b1; cyc(); lock_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (clear_req) seen = 1'b1;
    end
    check({tag, "_clear_req"}, 32'(seen), 32'd1);
    lines_cleared = lines; clear_done = 1'b1;
    cyc();
    clear_done = 1'b0; lines_cleared = 3'd0;
    l  = (lines > 3'd4) ? 4 : int'(lines);
    ms = (ms + l > 31) ? 31 : ms + l;
    check({tag, "_score"}, 32'(score), 32'(ms));
    check({tag, "_state_spawn"}, 32'(state), 32'd1);
    exp_q.push_back({5'd4, 5'd0, 3'd0});
    serve_chk({tag, "_spawn"}, spawn_c);
    check({tag, "_shape"}, 32'(shape_id), 32'(shape_seq[spawn_idx % 7]));
    spawn_idx++;
    mx = 5'd4; my = 5'd0; mrot = 3'd0;
    if (spawn_c) begin
      check({tag, "_state_over"}, 32'(state), 32'd6);
      check({tag, "_game_over"}, 32'(game_over), 32'd1);
    end else begin
      check({tag, "_state_fall"}, 32'(state), 32'd2);
    end
  endtask

  logic [2:0] lines_tab [10];
  int         c0;

  // Directed sequence.
  initial begin
    shape_seq = '{3'd1, 3'd4, 3'd2, 3'd6, 3'd5, 3'd3, 3'd0};
    lines_tab = '{3'd3, 3'd7, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd4, 3'd4};
    resetn = 1'b0; start = 1'b0; left_final = 1'b0; right_final = 1'b0;
    rot_final = 1'b0; tick_gravity = 1'b0; chk_done = 1'b0; collide = 1'b0;
    lock_done = 1'b0; clear_done = 1'b0; lines_cleared = 3'd0;
    mx = 5'd4; my = 5'd0; mrot = 3'd0; ms = 0; spawn_idx = 0;

    repeat (10) cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_piece", 32'({piece_x, piece_y, rot}), 32'({5'd4, 5'd0, 3'd0}));
    check("rst_shape", 32'(shape_id), 32'd1);
    check("rst_score", 32'(score), 32'd0);
    check("rst_outs", 32'({chk_req, lock_req, clear_req, move_accept, game_over}), 32'd0);
    resetn = 1'b1;
    cyc();

    // Start: spawn check at (4,0,0).
    start = 1'b1; cyc(); start = 1'b0;
    check("start_state", 32'(state), 32'd1);
    exp_q.push_back({5'd4, 5'd0, 3'd0});
    serve_chk("spawn0", 1'b0);
    check("spawn0_state", 32'(state), 32'd2);
    check("spawn0_piece", 32'({piece_x, piece_y, rot}), 32'({5'd4, 5'd0, 3'd0}));
    check("spawn0_shape", 32'(shape_id), 32'(shape_seq[0]));
    spawn_idx = 1;

    for (int i = 0; i < 8; i++) do_move("grav", 0, 1'b0);
    check("grav8_y", 32'(piece_y), 32'd8);
    check("grav8_score", 32'(score), 32'd0);

    // Gravity and left together: gravity first, then left.
    exp_q.push_back({mx, my + 5'd1, mrot});
    exp_q.push_back({mx - 5'd1, my + 5'd1, mrot});
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    serve_chk("gl_grav", 1'b0);
    my = my + 5'd1;
    check("gl_grav_piece", 32'({piece_x, piece_y}), 32'({mx, my}));
    serve_chk("gl_left", 1'b0);
    mx = mx - 5'd1;
    check("gl_left_piece", 32'({piece_x, piece_y}), 32'({5'd3, 5'd9}));

    // Left and right together cancel.
    c0 = chk_cnt;
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) cyc();
    check("lr_no_chk", 32'(chk_cnt), 32'(c0));
    check("lr_piece_x", 32'(piece_x), 32'(mx));
    check("lr_state", 32'(state), 32'd2);

    do_move("rot_collide", 1, 1'b1);
    do_move("rot_ok", 1, 1'b0);
    do_move("right", 3, 1'b0);
    for (int i = 0; i < 4; i++) do_move("left", 2, 1'b0);

    // Left at the wall is rejected locally.
    c0 = chk_cnt;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc();
    check("lwall_no_chk", 32'(chk_cnt), 32'(c0));
    check("lwall_piece_x", 32'(piece_x), 32'd0);
    check("lwall_state", 32'(state), 32'd2);

    for (int i = 0; i < 10; i++) do_move("fall", 0, 1'b0);
    check("bottom_y", 32'(piece_y), 32'd19);

    // Gravity at the bottom row locks without a check.
    c0 = chk_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    lock_clear_spawn("lock_bottom", lines_tab[0], 1'b0);
    check("lock_bottom_no_chk", 32'(chk_cnt), 32'(c0 + 1));

    for (int k = 1; k < 10; k++) begin
      do_move("grav_collide", 0, 1'b1);
      lock_clear_spawn("lock", lines_tab[k], 1'b0);
    end
    check("score_sat", 32'(score), 32'd31);

    // Spawn collision ends the game; start restarts with score 0.
    do_move("grav_collide", 0, 1'b1);
    lock_clear_spawn("over", 3'd0, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    ms = 0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    exp_q.push_back({5'd4, 5'd0, 3'd0});
    serve_chk("respawn", 1'b0);
    check("respawn_shape", 32'(shape_id), 32'(shape_seq[spawn_idx % 7]));
    spawn_idx++;

    // Reset in the middle of a check.
    exp_q.push_back({5'd4, 5'd1, 3'd0});
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    c0 = 0;
    for (int i = 0; i < 20 && c0 == 0; i++) begin
      @(negedge CLOCK_50);
      if (chk_req) c0 = 1;
    end
    check("midrst_chk_seen", 32'(c0), 32'd1);
    if (exp_q.size() != 0) check("midrst_cand", 32'({cand_x, cand_y, cand_rot}), 32'(exp_q.pop_front()));
    resetn = 1'b0;
    cyc();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_chk_req", 32'(chk_req), 32'd0);
    check("midrst_piece", 32'({piece_x, piece_y, rot}), 32'({5'd4, 5'd0, 3'd0}));
    check("midrst_shape", 32'(shape_id), 32'd1);
    resetn = 1'b1;
    cyc();

`ifdef GAMECTRL_WATCHDOG_EN
    check("wd_err_clear", 32'(chk_err), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (25) cyc();
    check("wd_err_set", 32'(chk_err), 32'd1);
    check("wd_state_over", 32'(state), 32'd6);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
